ppm_frame_rx: RTL and testbench
===============================

Name: ppm_frame_rx

Overview:
Downstream consumer of the PPM decoder's byte stream (Dout/D_en/F_en). It collects the bytes of one received frame into a local buffer and closes the frame after an idle timeout, since the decoder exports no EOF strobe. It checks the ISO/IEC 13239 CRC-16 over the whole frame and presents the result, with a byte read port, to the protocol/host logic. It runs in the decoder's system clock domain.

Parameters:
DEPTH, 32, maximum stored bytes per frame (power of 2, ≥4)
TIMEOUT, 2048, idle clk cycles after the last F_en/D_en that close a frame

Ports:
clk  in  1  system clock, same as decoder
rst_n  in  1  asynchronous active-low reset
din  in  8  decoded byte (decoder Dout)
d_en  in  1  one-cycle byte-valid strobe (decoder D_en)
f_en  in  1  one-cycle SOF strobe (decoder F_en)
rd_en  in  1  host read request, one byte per asserted cycle
rd_data  out  8  read byte, registered
rd_valid  out  1  rd_data valid, 1 cycle after an accepted rd_en
frame_rdy  out  1  level: complete frame held, readable
frame_len  out  $clog2(DEPTH+1)  stored byte count, valid while frame_rdy
crc_ok  out  1  CRC residue matched, valid while frame_rdy
ovf  out  1  frame exceeded DEPTH, valid while frame_rdy
frame_drop  out  1  one-cycle pulse: SOF arrived while a frame was held, new frame ignored

Behaviour:
- Reset: all outputs 0; state IDLE; counters, pointers and CRC cleared (CRC to 0xFFFF). Reset mid-frame or mid-read discards everything.
- States: IDLE, RECV, DONE.
- IDLE: f_en -> RECV, len=0, crc=0xFFFF, timer=0. d_en without prior f_en is ignored.
- RECV:
  - d_en: if len<DEPTH, store byte at mem[len], len+1; else set ovf and drop the byte. CRC updates on every d_en, including dropped bytes.
  - Timer clears on d_en or f_en and otherwise increments. When it reaches TIMEOUT-1 the next cycle ends the frame.
  - f_en in RECV: restart (len=0, crc=0xFFFF, ovf=0). If d_en is asserted the same cycle, that byte becomes byte 0 of the new frame with a fresh CRC.
  - f_en and d_en together in IDLE: same rule as above.
  - Frame end with len==0 and ovf==0: return to IDLE silently.
  - Frame end otherwise: DONE, frame_rdy=1. crc_ok=1 only if the final CRC register == 0xF0B8, ovf==0 and total received bytes ≥3.
- CRC-16: reflected polynomial 0x8408, init 0xFFFF, bits processed LSB-first, one byte per d_en in one cycle. The transmitted CRC is the complement, low byte first, so the residue over data plus CRC is 0xF0B8.
- DONE:
  - rd_en with rd_ptr<frame_len: rd_data<=mem[rd_ptr], rd_valid=1 next cycle, rd_ptr+1.
  - rd_en with rd_ptr==frame_len: ignored.
  - The read cycle that returns the last byte (rd_ptr reaching frame_len) also drops frame_rdy, crc_ok and ovf and moves to IDLE. An ovf frame with len=DEPTH reads DEPTH bytes.
  - f_en in DONE: frame_drop pulse, strobe ignored; d_en ignored.
- frame_len, crc_ok and ovf are stable for the whole time frame_rdy is high. rd_en is ignored outside DONE.

Decomposition:
- Package ppm_pkg: state enum (IDLE/RECV/DONE), CRC16_INIT=16'hFFFF, CRC16_POLY=16'h8408, CRC16_RESIDUE=16'hF0B8, and a crc16_byte(crc, byte) function.
- One natural sub-module: ppm_crc16 (registered CRC with clear/update inputs, instantiating crc16_byte).
- Byte memory is a plain register array inside ppm_frame_rx.

Test Plan:
- Good frame: f_en, then bytes 0x31..0x39, 0x6E, 0x90 spaced 160 clk apart, then idle. Expect frame_rdy at last d_en+TIMEOUT+1, frame_len=11, crc_ok=1, ovf=0. Read 11 times returns 0x31..0x39,0x6E,0x90 with rd_valid 1 cycle after each rd_en, then frame_rdy=0.
- Bad CRC: same stream with last byte 0x91 -> frame_len=11, crc_ok=0.
- Overflow (DEPTH=32): 40 bytes after f_en -> ovf=1, frame_len=32, crc_ok=0; reads return the first 32 bytes.
- Restart and empty frame: f_en, 3 bytes, f_en together with d_en=0xAA, then 2 bytes -> frame_len=3, first read returns 0xAA. Separately, f_en with no bytes -> no frame_rdy, returns to IDLE.
- Held-frame collision: during DONE, f_en plus 4 d_en -> frame_drop single pulse; held frame contents and frame_len unchanged.
- Reset: assert rst_n=0 mid-RECV and mid-read -> all outputs 0 immediately; after release, a subsequent good frame decodes correctly.

Source files
------------

// File: rtl/ppm_pkg.sv
// Shared types and CRC-16 helpers for the PPM frame receiver.
// Reflected polynomial, LSB-first, one byte per call.
package ppm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY    = 16'h8408;
    localparam logic [15:0] CRC16_RESIDUE = 16'hF0B8;

    function automatic logic [15:0] crc16_byte(
        input logic [15:0] crc,
        input logic [7:0]  data
    );
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i])
                c = (c >> 1) ^ CRC16_POLY;
            else
                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/ppm_crc16.sv
// Registered CRC-16 accumulator.
// Clear together with update seeds a fresh CRC with the given byte.
module ppm_crc16
    import ppm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        update,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // Restart from the init value or fold in one byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= CRC16_INIT;
        else if (clear)
            crc <= update ? crc16_byte(CRC16_INIT, data) : CRC16_INIT;
        else if (update)
            crc <= crc16_byte(crc, data);
    end

endmodule

// File: rtl/ppm_frame_rx.sv
// Frame collector behind the PPM decoder byte stream.
// Frames close on an idle timeout and are checked with CRC-16.
module ppm_frame_rx
    import ppm_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 2048
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 din,
    input  logic                       d_en,
    input  logic                       f_en,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic                       frame_rdy,
    output logic [$clog2(DEPTH+1)-1:0] frame_len,
    output logic                       crc_ok,
    output logic                       ovf,
    output logic                       frame_drop
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    state_t          state;
    state_t          state_nx;
    logic [LW-1:0]   len;
    logic [LW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;
    logic            ovf_acc;
    logic [15:0]     crc;
    logic [7:0]      mem [DEPTH];

    logic            start;
    logic            take;
    logic            store;
    logic            idle_out;
    logic            keep;
    logic            close;
    logic            rd_ok;
    logic            rd_last;
    logic            crc_good;
    logic [AW-1:0]   wr_addr;

    assign keep     = (len != '0) || ovf_acc;
    assign close    = idle_out && keep;
    assign rd_last  = rd_ok && (rd_ptr + LW'(1) == len);
    assign store    = take && (start || len < LW'(DEPTH));
    assign wr_addr  = start ? '0 : len[AW-1:0];
    assign crc_good = (crc == CRC16_RESIDUE) && !ovf_acc
                      && (len >= LW'(3));
    assign frame_len = len;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        take     = 1'b0;
        idle_out = 1'b0;
        rd_ok    = 1'b0;
        unique case (state)
            IDLE: begin
                start = f_en;
                take  = f_en && d_en;
                if (f_en)
                    state_nx = RECV;
            end
            RECV: begin
                start    = f_en;
                take     = d_en;
                idle_out = !f_en && !d_en
                           && (timer == TW'(TIMEOUT - 1));
                if (idle_out)
                    state_nx = keep ? DONE : IDLE;
            end
            DONE: begin
                rd_ok = rd_en && (rd_ptr < len);
                if (rd_ok && (rd_ptr + LW'(1) == len))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Byte count, overflow flag and idle timer while receiving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len     <= '0;
            ovf_acc <= 1'b0;
            timer   <= '0;
        end else begin
            if (start) begin
                len     <= take ? LW'(1) : '0;
                ovf_acc <= 1'b0;
            end else if (take) begin
                if (len < LW'(DEPTH))
                    len <= len + LW'(1);
                else
                    ovf_acc <= 1'b1;
            end
            if (start || take)
                timer <= '0;
            else if (state == RECV)
                timer <= timer + TW'(1);
        end
    end

    // Frame byte storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (store)
            mem[wr_addr] <= din;
    end

    ppm_crc16 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start),
        .update (take),
        .data   (din),
        .crc    (crc)
    );

    // Frame status, held stable from close until the last read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_rdy <= 1'b0;
            crc_ok    <= 1'b0;
            ovf       <= 1'b0;
        end else if (close) begin
            frame_rdy <= 1'b1;
            crc_ok    <= crc_good;
            ovf       <= ovf_acc;
        end else if (rd_last) begin
            frame_rdy <= 1'b0;
            crc_ok    <= 1'b0;
            ovf       <= 1'b0;
        end
    end

    // Host read port and collision strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            rd_valid   <= rd_ok;
            frame_drop <= (state == DONE) && f_en;
            if (close)
                rd_ptr <= '0;
            else if (rd_ok) begin
                rd_ptr  <= rd_ptr + LW'(1);
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_ppm_frame_rx.sv
// Bench for ppm_frame_rx: directed frames plus random traffic.
// A queue-based frame model predicts every output each cycle.
module tb_ppm_frame_rx;

    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 200;
    localparam int LW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    din;
    logic          d_en;
    logic          f_en;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          frame_rdy;
    logic [LW-1:0] frame_len;
    logic          crc_ok;
    logic          ovf;
    logic          frame_drop;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int drop_cnt = 0;

    ppm_frame_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .d_en       (d_en),
        .f_en       (f_en),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_rdy  (frame_rdy),
        .frame_len  (frame_len),
        .crc_ok     (crc_ok),
        .ovf        (ovf),
        .frame_drop (frame_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) drop_cnt += int'(frame_drop);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // CRC over a whole byte list, reflected 0x8408, init 0xFFFF.
    function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {8'h00, q[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    // Model: 0 = no frame, 1 = collecting, 2 = frame held.
    int         m_phase;
    logic [7:0] m_q[$];
    logic [7:0] m_held[$];
    int         m_idle;
    int         m_rptr;
    int         m_len;
    logic       m_ok;
    logic       m_ovf;
    logic       m_rv;
    logic       m_drop;
    logic [7:0] m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_q.delete();
            m_held.delete();
            m_idle = 0;
            m_rptr = 0;
            m_len  = 0;
            m_ok   = 1'b0;
            m_ovf  = 1'b0;
            m_rv   = 1'b0;
            m_drop = 1'b0;
            m_rd   = 8'h00;
        end else begin
            m_rv   = 1'b0;
            m_drop = 1'b0;
            case (m_phase)
                0: if (f_en) begin
                    m_phase = 1;
                    m_q.delete();
                    m_idle = 0;
                    if (d_en) m_q.push_back(din);
                end
                1: if (f_en || d_en) begin
                    if (f_en) m_q.delete();
                    if (d_en) m_q.push_back(din);
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        if (m_q.size() == 0) begin
                            m_phase = 0;
                        end else begin
                            m_phase = 2;
                            m_held  = m_q;
                            m_ovf   = m_q.size() > DEPTH;
                            m_len   = m_ovf ? DEPTH : m_q.size();
                            m_ok    = !m_ovf && m_q.size() >= 3
                                      && crc_of(m_q) == 16'hF0B8;
                            m_rptr  = 0;
                        end
                    end
                end
                default: begin
                    if (f_en) m_drop = 1'b1;
                    if (rd_en && m_rptr < m_len) begin
                        m_rd = m_held[m_rptr];
                        m_rv = 1'b1;
                        m_rptr++;
                        if (m_rptr == m_len) m_phase = 0;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("frame_rdy", frame_rdy, m_phase == 2);
        chk("rd_valid", rd_valid, m_rv);
        chk("frame_drop", frame_drop, m_drop);
        if (m_rv) chk("rd_data", rd_data, m_rd);
        if (m_phase == 2) begin
            chk("frame_len", frame_len, m_len);
            chk("crc_ok", crc_ok, m_ok);
            chk("ovf", ovf, m_ovf);
        end else begin
            chk("crc_ok_idle", crc_ok, 0);
            chk("ovf_idle", ovf, 0);
        end
    end

    task automatic drive(input logic f, input logic d,
                         input logic [7:0] b, input logic r);
        @(posedge clk);
        #1;
        f_en = f; d_en = d; din = b; rd_en = r;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 8'h00, 0);
    endtask

    task automatic wait_rdy(input string nm, output int at);
        at = -1;
        for (int i = 0; i < TIMEOUT + 20; i++) begin
            drive(0, 0, 8'h00, 0);
            @(negedge clk);
            if (frame_rdy) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: frame_rdy never rose", nm);
        end
    endtask

    task automatic read_check(input logic [7:0] exp[$]);
        foreach (exp[i]) begin
            drive(0, 0, 8'h00, 1);
            drive(0, 0, 8'h00, 0);
            @(negedge clk);
            chk("lit_rd_valid", rd_valid, 1);
            chk("lit_rd_data", rd_data, exp[i]);
        end
        @(negedge clk);
        chk("lit_rdy_after_read", frame_rdy, 0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_rdy"}, frame_rdy, 0);
        chk({nm, "_rv"}, rd_valid, 0);
        chk({nm, "_rd"}, rd_data, 0);
        chk({nm, "_len"}, frame_len, 0);
        chk({nm, "_ok"}, crc_ok, 0);
        chk({nm, "_ovf"}, ovf, 0);
        chk({nm, "_drop"}, frame_drop, 0);
    endtask

    task automatic good_frame(input logic [7:0] last, output int lat);
        logic [7:0] gf[$];
        int t0;
        int at;
        gf = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
               8'h37, 8'h38, 8'h39, 8'h6E, last};
        drive(1, 0, 8'h00, 0);
        idle(10);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, gf[i], 0);
            idle(159);
        end
        drive(0, 1, gf[10], 0);
        t0 = cyc;
        wait_rdy("good_frame_rdy", at);
        lat = at - t0;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp[$];
    int lat;

    initial begin
        rst_n = 1'b0;
        f_en = 0; d_en = 0; din = 0; rd_en = 0;
        #3;
        check_zero("lit_reset");
        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
              8'h36, 8'h37, 8'h38, 8'h39};
        chk("lit_crc_model", crc_of(q), 16'h6F91);
        q.push_back(8'h6E);
        q.push_back(8'h90);
        chk("lit_residue_model", crc_of(q), 16'hF0B8);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // Good frame and exact close latency.
        good_frame(8'h90, lat);
        chk("lit_latency", lat, TIMEOUT + 1);
        chk("lit_len_good", frame_len, 11);
        chk("lit_ok_good", crc_ok, 1);
        chk("lit_ovf_good", ovf, 0);
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
        read_check(exp);

        // Corrupted CRC byte.
        good_frame(8'h91, lat);
        chk("lit_len_bad", frame_len, 11);
        chk("lit_ok_bad", crc_ok, 0);
        exp[10] = 8'h91;
        read_check(exp);

        // Overflow.
        drive(1, 0, 8'h00, 0);
        exp.delete();
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, 8'(i + 1), 0);
            idle(2);
            if (i < DEPTH) exp.push_back(8'(i + 1));
        end
        wait_rdy("ovf_rdy", lat);
        chk("lit_ovf_flag", ovf, 1);
        chk("lit_ovf_len", frame_len, DEPTH);
        chk("lit_ovf_ok", crc_ok, 0);
        read_check(exp);

        // Empty frame returns silently.
        drive(1, 0, 8'h00, 0);
        idle(TIMEOUT + 10);
        @(negedge clk);
        chk("lit_empty_rdy", frame_rdy, 0);

        // Restart mid-frame, then collision while held.
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h01, 0);
        drive(0, 1, 8'h02, 0);
        drive(0, 1, 8'h03, 0);
        drive(1, 1, 8'hAA, 0);
        drive(0, 1, 8'hBB, 0);
        drive(0, 1, 8'hCC, 0);
        wait_rdy("restart_rdy", lat);
        chk("lit_restart_len", frame_len, 3);
        drop_cnt = 0;
        drive(1, 1, 8'h55, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 8'h56, 0);
        idle(3);
        @(negedge clk);
        chk("lit_drop_pulses", drop_cnt, 1);
        chk("lit_held_len", frame_len, 3);
        exp = '{8'hAA, 8'hBB, 8'hCC};
        read_check(exp);

        // Reset in the middle of reception.
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h11, 0);
        drive(0, 1, 8'h22, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("lit_rst_recv");
        idle(2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(TIMEOUT + 5);
        @(negedge clk);
        chk("lit_rst_recv_gone", frame_rdy, 0);

        // Reset in the middle of a read.
        good_frame(8'h90, lat);
        drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 0);
        #2 rst_n = 1'b0;
        #1 check_zero("lit_rst_read");
        idle(2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        good_frame(8'h90, lat);
        chk("lit_post_rst_ok", crc_ok, 1);
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
        read_check(exp);

        // Random frames with noise on every input.
        for (int k = 0; k < 24; k++) begin
            int nb;
            logic [15:0] c;
            int n;
            nb = $urandom_range(0, 40);
            q.delete();
            for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
            if (nb > 0 && $urandom_range(0, 1) == 1) begin
                c = ~crc_of(q);
                q.push_back(c[7:0]);
                q.push_back(c[15:8]);
            end
            drive(1, 0, 8'h00, 0);
            foreach (q[i]) begin
                if ($urandom_range(0, 15) == 0)
                    drive(1, 1, q[i], 0);
                else
                    drive(0, 1, q[i], 1'($urandom));
                repeat ($urandom_range(0, 4))
                    drive(0, 0, 8'h00, 1'($urandom));
            end
            repeat (TIMEOUT + 4) drive(0, 0, 8'h00, 1'($urandom));
            n = 0;
            while (frame_rdy && n < 200) begin
                drive($urandom_range(0, 9) == 0, 1'($urandom),
                      8'($urandom), 1'($urandom));
                n++;
            end
        end
        repeat (TIMEOUT + 4) drive(0, 0, 8'h00, 0);
        for (int i = 0; i < 40; i++) drive(0, 0, 8'h00, 1);
        idle(3);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
